mobo_bus_ctrl: RTL and testbench
================================

MOBO_BUS_CTRL -- requirements
Module: mobo_bus_ctrl

Interface
REQ-001 Parameter word_width, default 32, SHALL set the width of all data, address, control and status buses.
REQ-002 Parameter timeout_cycles, default 16, SHALL set the WAIT-state cycle limit used when the timeout feature is compiled in.
REQ-003 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  SHALL be the reset; it is synchronous and active-high.
REQ-005 mobo_ctrl  input  word_width  SHALL carry CPU commands: bit0 read request, bit1 write request, bit2 acknowledge; other bits ignored.
REQ-006 mobo_stat  output  word_width  SHALL report status: bit0 busy, bit1 done, bit2 timeout error, bit3 illegal-request error; bits [word_width-1:4] always 0.
REQ-007 addr  input  word_width  SHALL be the CPU transfer address.
REQ-008 data_in  input  word_width  SHALL be the CPU write data.
REQ-009 data_out  output  word_width  SHALL be the read data returned to the CPU.
REQ-010 mem_addr, mem_wdata  output  word_width  SHALL be the latched address and write data presented to memory.
REQ-011 mem_re, mem_we  output  1  SHALL be the memory read and write strobes.
REQ-012 mem_rdata  input  word_width  SHALL be the memory read data; mem_ready  input  1  SHALL be the memory completion flag.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT, DONE. All outputs SHALL be registered.
REQ-014 In IDLE, at an edge where exactly one of ctrl bit0/bit1 is 1: latch addr to mem_addr and data_in to mem_wdata, assert mem_re (read) or mem_we (write), set busy, and go to WAIT.
REQ-015 In IDLE, at an edge where both bit0 and bit1 are 1: perform no memory access, set stat bit3 and done, and go to DONE.
REQ-016 In WAIT, mem_addr, mem_wdata and the active strobe SHALL be held stable.
REQ-017 In WAIT, at an edge with mem_ready=1: drop both strobes, clear busy, set done, and go to DONE; for a read, also capture mem_rdata into data_out at that same edge.
REQ-018 Minimum latency SHALL be 2 edges, request edge to done visible, when mem_ready is already 1.
REQ-019 A write SHALL leave data_out unchanged.
REQ-020 In DONE, at an edge with ctrl bit2=1: clear done, bit2 and bit3, and go to IDLE.
REQ-021 Request bits SHALL be ignored in WAIT and DONE.
REQ-022 If acknowledge and a request are both set at the DONE edge, only the acknowledge SHALL act; the CPU must reissue the request in IDLE.
REQ-023 mem_ready in IDLE or DONE SHALL be ignored.
REQ-024 mem_re and mem_we SHALL never be asserted simultaneously.

Reset
REQ-025 At an edge with rst=1, state SHALL become IDLE and mobo_stat, data_out, mem_addr, mem_wdata, mem_re, mem_we and the timeout counter SHALL become 0; rst overrides all other inputs.
REQ-026 Reset during WAIT SHALL abort the transfer and drop the strobes at that same edge; no done SHALL be reported.

Configuration
REQ-027 With macro MOBO_BUS_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and increment on each WAIT edge with mem_ready=0.
REQ-028 With MOBO_BUS_TIMEOUT_EN defined, when the counter reaches timeout_cycles the block SHALL drop the strobes, set stat bit2 and done, clear busy, leave data_out unchanged, and go to DONE.
REQ-029 With MOBO_BUS_TIMEOUT_EN defined, if mem_ready=1 on the expiry edge, completion SHALL win and bit2 SHALL stay 0.
REQ-030 Without MOBO_BUS_TIMEOUT_EN, WAIT SHALL last indefinitely and stat bit2 SHALL always be 0.

Verification
REQ-031 Read, mem_ready tied 1, addr=0x10, mem_rdata=0xDEADBEEF -> mem_re high 1 cycle, data_out=0xDEADBEEF, stat=0x2 two edges after the request edge.
REQ-032 Write addr=0x20, data_in=5, mem_ready asserted after 3 WAIT cycles -> mem_we held 3 cycles with mem_addr=0x20 and mem_wdata=5, then stat=0x2, data_out unchanged.
REQ-033 ctrl=0x3 in IDLE -> no strobe ever asserted, stat=0x0A; ctrl=0x4 then -> stat=0 and state IDLE.
REQ-034 With MOBO_BUS_TIMEOUT_EN and timeout_cycles=4, read with mem_ready held 0 -> strobe drops after 4 WAIT edges, stat=0x6.
REQ-035 rst=1 during WAIT of a read -> next cycle strobes 0, stat=0, data_out=0; a new read then completes normally.
REQ-036 In DONE, ctrl=0x5 (ack plus read) -> return to IDLE with no memory access; a later ctrl=0x1 starts the read.

Source files
------------

// File: rtl/mobo_bus_ctrl.sv
// CPU-to-memory bus controller: three-state handshake (IDLE/WAIT/DONE) with registered outputs.
// Optional WAIT-state timeout is compiled in with macro MOBO_BUS_TIMEOUT_EN.
module mobo_bus_ctrl #(
   parameter int word_width     = 32,
   parameter int timeout_cycles = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [word_width-1:0] mobo_ctrl,
   output logic [word_width-1:0] mobo_stat,
   input  logic [word_width-1:0] addr,
   input  logic [word_width-1:0] data_in,
   output logic [word_width-1:0] data_out,
   output logic [word_width-1:0] mem_addr,
   output logic [word_width-1:0] mem_wdata,
   output logic                  mem_re,
   output logic                  mem_we,
   input  logic [word_width-1:0] mem_rdata,
   input  logic                  mem_ready
);

   localparam int cnt_w = $clog2(timeout_cycles + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  to_err_q, to_err_d;
   logic                  ill_err_q, ill_err_d;
   logic                  mem_re_q, mem_re_d;
   logic                  mem_we_q, mem_we_d;
   logic [word_width-1:0] data_out_q, data_out_d;
   logic [word_width-1:0] mem_addr_q, mem_addr_d;
   logic [word_width-1:0] mem_wdata_q, mem_wdata_d;
   logic [cnt_w-1:0]      to_cnt_q, to_cnt_d;

   logic rd_req;
   logic wr_req;
   logic ack;
   logic expired;
   logic unused_ctrl;

   assign rd_req      = mobo_ctrl[0];
   assign wr_req      = mobo_ctrl[1];
   assign ack         = mobo_ctrl[2];
   assign unused_ctrl = &{1'b0, mobo_ctrl[word_width-1:3]};

   // Expiry fires on the WAIT edge that would bring the counter up to timeout_cycles.
`ifdef MOBO_BUS_TIMEOUT_EN
   assign expired = (to_cnt_q == cnt_w'(timeout_cycles - 1));
`else
   assign expired = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      done_d      = done_q;
      to_err_d    = to_err_q;
      ill_err_d   = ill_err_q;
      mem_re_d    = mem_re_q;
      mem_we_d    = mem_we_q;
      data_out_d  = data_out_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      to_cnt_d    = to_cnt_q;

      case (state_q)
         IDLE: begin
            if (rd_req && wr_req) begin
               ill_err_d = 1'b1;
               done_d    = 1'b1;
               state_d   = DONE;
            end else if (rd_req || wr_req) begin
               mem_addr_d  = addr;
               mem_wdata_d = data_in;
               mem_re_d    = rd_req;
               mem_we_d    = wr_req;
               busy_d      = 1'b1;
               to_cnt_d    = '0;
               state_d     = WAIT;
            end
         end

         WAIT: begin
            // Completion takes priority over a simultaneous timeout expiry.
            if (mem_ready) begin
               if (mem_re_q) begin
                  data_out_d = mem_rdata;
               end
               mem_re_d = 1'b0;
               mem_we_d = 1'b0;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               state_d  = DONE;
            end else if (expired) begin
               to_cnt_d = to_cnt_q + cnt_w'(1);
               mem_re_d = 1'b0;
               mem_we_d = 1'b0;
               busy_d   = 1'b0;
               done_d   = 1'b1;
               to_err_d = 1'b1;
               state_d  = DONE;
            end else if (to_cnt_q != cnt_w'(timeout_cycles)) begin
               to_cnt_d = to_cnt_q + cnt_w'(1);
            end
         end

         DONE: begin
            if (ack) begin
               done_d    = 1'b0;
               to_err_d  = 1'b0;
               ill_err_d = 1'b0;
               state_d   = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         to_err_q    <= 1'b0;
         ill_err_q   <= 1'b0;
         mem_re_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         data_out_q  <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         to_cnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         to_err_q    <= to_err_d;
         ill_err_q   <= ill_err_d;
         mem_re_q    <= mem_re_d;
         mem_we_q    <= mem_we_d;
         data_out_q  <= data_out_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         to_cnt_q    <= to_cnt_d;
      end
   end

   assign mobo_stat = {{(word_width-4){1'b0}}, ill_err_q, to_err_q, done_q, busy_q};
   assign data_out  = data_out_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_re    = mem_re_q;
   assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_mobo_bus_ctrl.sv
// Testbench for mobo_bus_ctrl: directed and randomized transfers checked against a
// transaction-level model; timeout expectations follow MOBO_BUS_TIMEOUT_EN.
module tb_mobo_bus_ctrl;

   localparam int W = 32;
   localparam int T = 4;

`ifdef MOBO_BUS_TIMEOUT_EN
   localparam bit TimeoutEn = 1'b1;
`else
   localparam bit TimeoutEn = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] mobo_ctrl;
   logic [W-1:0] mobo_stat;
   logic [W-1:0] addr;
   logic [W-1:0] data_in;
   logic [W-1:0] data_out;
   logic [W-1:0] mem_addr;
   logic [W-1:0] mem_wdata;
   logic         mem_re;
   logic         mem_we;
   logic [W-1:0] mem_rdata;
   logic         mem_ready;

   int           testsRun    = 0;
   int           testsFailed = 0;
   logic [W-1:0] expDataOut;

   mobo_bus_ctrl #(
      .word_width     (W),
      .timeout_cycles (T)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .mobo_ctrl (mobo_ctrl),
      .mobo_stat (mobo_stat),
      .addr      (addr),
      .data_in   (data_in),
      .data_out  (data_out),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_re    (mem_re),
      .mem_we    (mem_we),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it, away from the next edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      testsRun++;
      assert (got === exp)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic [W-1:0] ctrl, input logic rdy);
      mobo_ctrl = ctrl;
      mem_ready = rdy;
      step();
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_stat"}, mobo_stat, '0);
      checkOutput({tag, "_re"}, W'(mem_re), '0);
      checkOutput({tag, "_we"}, W'(mem_we), '0);
      checkOutput({tag, "_dout"}, data_out, expDataOut);
   endtask

   // One complete transfer: request, d WAIT edges without ready, DONE dwell, acknowledge.
   task automatic runTransfer(input bit isWrite, input logic [W-1:0] a, input logic [W-1:0] wd,
                              input logic [W-1:0] rd, input int d, input bit ackWithReq);
      bit timedOut;
      int lastK;
      logic [W-1:0] expStat;
      timedOut = TimeoutEn && (d >= T);
      lastK    = timedOut ? T : d + 1;
      addr      = a;
      data_in   = wd;
      mem_rdata = rd;
      applyStimulus(W'(isWrite ? 2 : 1), 1'($urandom_range(0, 1)));
      for (int k = 1; k <= lastK; k++) begin
         checkOutput("wait_stat", mobo_stat, W'(1));
         checkOutput("wait_re", W'(mem_re), W'(!isWrite));
         checkOutput("wait_we", W'(mem_we), W'(isWrite));
         checkOutput("wait_addr", mem_addr, a);
         checkOutput("wait_wdata", mem_wdata, wd);
         checkOutput("wait_dout", data_out, expDataOut);
         addr    = $urandom;
         data_in = $urandom;
         applyStimulus(W'($urandom_range(0, 3)), k > d);
      end
      if (!isWrite && !timedOut) begin
         expDataOut = rd;
      end
      expStat   = timedOut ? W'(6) : W'(2);
      mem_rdata = $urandom;
      checkOutput("done_stat", mobo_stat, expStat);
      checkOutput("done_re", W'(mem_re), '0);
      checkOutput("done_we", W'(mem_we), '0);
      checkOutput("done_dout", data_out, expDataOut);
      applyStimulus(W'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      checkOutput("dwell_stat", mobo_stat, expStat);
      checkOutput("dwell_re", W'(mem_re | mem_we), '0);
      applyStimulus(ackWithReq ? W'(4 + $urandom_range(1, 3)) : W'(4), 1'($urandom_range(0, 1)));
      checkIdle("ack");
      applyStimulus('0, 1'($urandom_range(0, 1)));
      checkIdle("post_ack");
   endtask

   initial begin
      rst        = 1'b1;
      mobo_ctrl  = W'(1);
      mem_ready  = 1'b1;
      addr       = W'(32'h55);
      data_in    = W'(32'h66);
      mem_rdata  = W'(32'h77);
      expDataOut = '0;
      step();
      step();
      checkIdle("reset");
      checkOutput("reset_addr", mem_addr, '0);
      checkOutput("reset_wdata", mem_wdata, '0);
      rst       = 1'b0;
      mobo_ctrl = '0;
      step();
      checkIdle("idle");

      // Directed read with memory already ready: done two edges after the request.
      runTransfer(1'b0, W'(32'h10), W'(32'h0), W'(32'hDEADBEEF), 0, 1'b0);
      // Directed write held for three cycles.
      runTransfer(1'b1, W'(32'h20), W'(32'h5), W'(32'h1234), 2, 1'b0);
      // Ready arriving on the would-be expiry edge completes normally.
      runTransfer(1'b0, W'(32'h30), W'(32'h0), W'(32'hCAFE0001), T - 1, 1'b0);
      // Long wait: times out when the feature is compiled in, completes otherwise.
      runTransfer(1'b0, W'(32'h40), W'(32'h0), W'(32'hBADC0DE5), 10, 1'b0);
      // Acknowledge combined with a request returns to IDLE without a new access.
      runTransfer(1'b0, W'(32'h44), W'(32'h0), W'(32'h0BADF00D), 1, 1'b1);

      // Both request bits: illegal, no strobe.
      applyStimulus(W'(3), 1'b1);
      checkOutput("ill_stat", mobo_stat, W'(32'h0A));
      checkOutput("ill_strobe", W'(mem_re | mem_we), '0);
      applyStimulus(W'(3), 1'b1);
      checkOutput("ill_hold", mobo_stat, W'(32'h0A));
      checkOutput("ill_strobe2", W'(mem_re | mem_we), '0);
      applyStimulus(W'(4), 1'b0);
      checkIdle("ill_ack");

      // Reset in the middle of a read aborts it.
      addr = W'(32'h50);
      mem_rdata = W'(32'h11112222);
      applyStimulus(W'(1), 1'b0);
      applyStimulus('0, 1'b0);
      checkOutput("rstw_re", W'(mem_re), W'(1));
      rst = 1'b1;
      applyStimulus('0, 1'b1);
      rst = 1'b0;
      expDataOut = '0;
      checkIdle("rstw");
      checkOutput("rstw_addr", mem_addr, '0);
      applyStimulus('0, 1'b1);
      checkIdle("rstw_after");
      runTransfer(1'b0, W'(32'h60), W'(32'h0), W'(32'h33334444), 1, 1'b0);

      for (int i = 0; i < 30; i++) begin
         runTransfer(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                     $urandom_range(0, 6), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   // Read and write strobes must never overlap.
   always @(negedge clk) begin
      if (rst === 1'b0 && mem_re === 1'b1 && mem_we === 1'b1) begin
         testsFailed++;
         $error("[TB] FAIL strobe_overlap: got re=%b we=%b expected not both", mem_re, mem_we);
      end
   end

endmodule
